irq_pend_arbiter: RTL
=====================

Name: irq_pend_arbiter

Overview:
- Interrupt pending/arbitration stage for the 8-input priority-encode path.
- Captures raw request lines into a pending register and applies an enable mask.
- Selects the highest-index eligible request (bit 7 highest, bit 0 lowest) and presents its 3-bit index downstream with a valid/ready handshake.
- Retires the serviced pending bit on acceptance and tracks lost (overrun) events per line.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 for this revision.
- IDX_W, 3, index width; must equal clog2(N_REQ).
- EDGE_MODE, 1, 1 = rising-edge capture, 0 = level capture.
- MASK_RST, 8'hFF, reset value of the enable mask.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_in  in  8  raw request lines, already synchronous to clk.
- mask_we  in  1  mask write strobe.
- mask_din  in  8  new mask value; 1 = line enabled.
- irq_valid  out  1  irq_idx holds a selected request.
- irq_ready  in  1  consumer accepts when irq_valid & irq_ready.
- irq_idx  out  3  index of the presented request.
- any_pend  out  1  OR of all pending bits, masked or not.
- pend_out  out  8  pending register, for status readback.
- ovf  out  8  sticky per-line overrun flags.
- ovf_clr  in  8  write-1-to-clear for ovf.

Behaviour:
- Reset (synchronous, rst high at a clk edge) drives:
  - pending=0, ovf=0, req_q=0, mask=MASK_RST.
  - state=IDLE, irq_valid=0, irq_idx=0; any_pend=0 follows.
  - rst has priority over every other input.
- Event detect:
  - req_q <= req_in every cycle.
  - EDGE_MODE=1: evt = req_in & ~req_q.
  - EDGE_MODE=0: evt = req_in.
- Pending update per bit i, each edge:
  - Set when evt[i].
  - Clear when accept & irq_idx==i.
  - Set and clear in the same cycle: set wins, because it is a new event.
- Overrun:
  - evt[i] while pending[i]=1 and not being cleared that cycle sets ovf[i].
  - ovf_clr[i] clears ovf[i]; a same-cycle set wins.
  - Level mode: ovf is not updated, because a held line would flag continuously.
- Mask:
  - mask_we loads mask_din at the edge; the new value affects eligibility from the next cycle.
  - eligible = pending & mask.
- Encoder: highest set bit of eligible gives sel_idx; sel_any = |eligible.
- FSM, two states:
  - IDLE: irq_valid=0. If sel_any, register irq_idx<=sel_idx and go to PRESENT.
  - PRESENT: irq_valid=1 and irq_idx held stable. On irq_ready, clear that pending bit and return to IDLE.
  - No retraction: masking the presented line or raising a higher-priority request while in PRESENT does not change irq_idx or drop irq_valid.
- Latency and throughput:
  - A rising edge on req_in sampled at edge k sets pending at edge k.
  - irq_valid rises after edge k+1, i.e. 2 cycles.
  - Minimum one IDLE cycle between accepts, so peak rate is 1 vector per 2 cycles.
- Re-arbitration: each IDLE pass recomputes from current eligible state, so a higher-priority request pending at that point wins.
- Reset while in PRESENT: vector dropped, pending lost, irq_valid low after that edge.
- Output timing: irq_valid, irq_idx, pend_out and ovf are registered; any_pend is combinational from pending only.

Decomposition:
- Package irq_pkg:
  - Constants N_REQ=8, IDX_W=3.
  - State encoding ST_IDLE=1'b0, ST_PRESENT=1'b1.
- Sub-module irq_prio_enc (combinational):
  - 8-bit eligible in; 3-bit index and any flag out.
  - Highest index wins; output 0 with any=0 when input is 0.
  - Reusable by the other encoder consumers.
- Top level holds event detect, pending/ovf/mask registers and the FSM.

Test Plan:
- Reset, then pulse req_in[5] 0->1 for one cycle with irq_ready=0 -> irq_valid=1, irq_idx=5 exactly 2 cycles after; holds until ready. Set ready -> pend_out=0, irq_valid=0 next cycle.
- Simultaneous rising edges on bits 1, 3 and 6, ready held high -> vectors 6, 3, 1 in order, one every 2 cycles, pend_out ends at 8'h00.
- mask_din=8'h7F with mask_we, then rise req_in[7] and req_in[2] -> vector 2 only; any_pend=1 with pend_out=8'h80. Write mask 8'hFF -> vector 7 follows.
- Second rise on req_in[4] while bit 4 is pending and unserviced -> ovf=8'h10. ovf_clr=8'h10 -> ovf=0; a simultaneous new overrun keeps it set.
- In PRESENT with idx=3, raise req_in[7] and clear mask bit 3 -> irq_idx stays 3 until accepted; next vector is 7.
- Assert rst while PRESENT and with pending=8'h24 -> after the edge irq_valid=0, irq_idx=0, pend_out=0, ovf=0; no vector afterwards without new edges.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending/arbitration path.
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: highest set bit of eligible wins; zero input gives idx=0, any=0.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [N_REQ-1:0] eligible,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan so the last (highest) set bit overrides lower ones.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (eligible[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pend_arbiter.sv
// Interrupt pending register, enable mask, overrun tracking and valid/ready vector presentation.
module irq_pend_arbiter #(
    parameter int               N_REQ     = irq_pkg::N_REQ,
    parameter int               IDX_W     = irq_pkg::IDX_W,
    parameter bit               EDGE_MODE = 1'b1,
    parameter logic [N_REQ-1:0] MASK_RST  = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic             mask_we,
    input  logic [N_REQ-1:0] mask_din,
    output logic             irq_valid,
    input  logic             irq_ready,
    output logic [IDX_W-1:0] irq_idx,
    output logic             any_pend,
    output logic [N_REQ-1:0] pend_out,
    output logic [N_REQ-1:0] ovf,
    input  logic [N_REQ-1:0] ovf_clr
);
    import irq_pkg::*;

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] evt;
    logic [N_REQ-1:0] clr_vec;
    logic [N_REQ-1:0] ovf_set;
    logic [N_REQ-1:0] eligible;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             accept;
    logic             load_idx;

    irq_state_t state, state_nxt;

    assign evt      = EDGE_MODE ? (req_in & ~req_q) : req_in;
    assign accept   = (state == ST_PRESENT) && irq_ready;
    assign eligible = pending & mask;

    always_comb begin
        clr_vec = '0;
        if (accept) clr_vec[irq_idx] = 1'b1;
    end

    // A pending line hit again counts as lost unless it is being retired this same edge.
    assign ovf_set = EDGE_MODE ? (evt & pending & ~clr_vec) : '0;

    irq_prio_enc u_enc (
        .eligible (eligible),
        .idx      (sel_idx),
        .any      (sel_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            pending <= '0;
            ovf     <= '0;
            mask    <= MASK_RST;
        end else begin
            req_q   <= req_in;
            pending <= (pending & ~clr_vec) | evt;
            ovf     <= (ovf & ~ovf_clr) | ovf_set;
            if (mask_we) mask <= mask_din;
        end
    end

    always_comb begin
        state_nxt = state;
        load_idx  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sel_any) begin
                    load_idx  = 1'b1;
                    state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (irq_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            irq_idx <= '0;
        end else begin
            state <= state_nxt;
            if (load_idx) irq_idx <= sel_idx;
        end
    end

    assign irq_valid = (state == ST_PRESENT);
    assign any_pend  = |pending;
    assign pend_out  = pending;

endmodule
